// File: rtl/jtpang_fmwr.sv
// Write-side scheduler for the YM2413 register port: buffers {a0,data} CPU writes
// in a FIFO and replays them on the fm_cs/wr_n bus with the chip's recovery gaps.
module jtpang_fmwr #(
  parameter int AW        = 4,
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          in_we,
  input  logic          in_a0,
  input  logic [7:0]    in_din,
  output logic          in_full,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          busy,
  output logic          fm_cs,
  output logic          wr_n,
  output logic          a0,
  output logic [7:0]    dout
);
  localparam int DEPTH = 2**AW;
  localparam int MAXW  = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int CW    = $clog2(MAXW + 1);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_WAIT} state_t;

  logic [8:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          avail_q, avail_d;
  logic          ovf_q, ovf_d, full_q, full_d, busy_q, busy_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cs_q, cs_d, wr_n_q, wr_n_d, a0_q, a0_d;
  logic [7:0]    dout_q, dout_d;
  logic          push, pop;

  // Pops wait for avail_q, one cycle behind level, so a freshly written entry has settled
  assign pop  = (state_q == ST_IDLE) && avail_q;
  assign push = in_we && (level_q != DEPTH_L);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + (AW+1)'(1);
    else if (!push && pop) level_d = level_q - (AW+1)'(1);
    ovf_d   = ovf_q | (in_we & ~push);
    full_d  = (level_d == DEPTH_L);
    avail_d = (level_q != '0);
    busy_d  = (level_d != '0) || (state_d != ST_IDLE);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (avail_q) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: if (cen) state_d = ST_WAIT;
      ST_WAIT:   if (cnt_q == '0) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cs_d   = cs_q;
    wr_n_d = wr_n_q;
    a0_d   = a0_q;
    dout_d = dout_q;
    cnt_d  = cnt_q;
    case (state_q)
      ST_IDLE: if (avail_q) begin
        a0_d   = fifo_mem[rd_ptr_q][8];
        dout_d = fifo_mem[rd_ptr_q][7:0];
        cs_d   = 1'b1;
      end
      ST_SETUP: wr_n_d = 1'b0;
      ST_STROBE: if (cen) begin
        wr_n_d = 1'b1;
        cs_d   = 1'b0;
        cnt_d  = a0_q ? CW'(DATA_WAIT) : CW'(ADDR_WAIT);
      end
      ST_WAIT: if (cen && cnt_q != '0) cnt_d = cnt_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      avail_q  <= 1'b0;
      ovf_q    <= 1'b0;
      full_q   <= 1'b0;
      busy_q   <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cs_q     <= 1'b0;
      wr_n_q   <= 1'b1;
      a0_q     <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      avail_q  <= avail_d;
      ovf_q    <= ovf_d;
      full_q   <= full_d;
      busy_q   <= busy_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cs_q     <= cs_d;
      wr_n_q   <= wr_n_d;
      a0_q     <= a0_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {in_a0, in_din};
  end

  assign in_full = full_q;
  assign level   = level_q;
  assign ovf     = ovf_q;
  assign busy    = busy_q;
  assign fm_cs   = cs_q;
  assign wr_n    = wr_n_q;
  assign a0      = a0_q;
  assign dout    = dout_q;
endmodule

// File: tb/tb_jtpang_fmwr.sv
// Bench for jtpang_fmwr: directed steps plus random traffic, checked against a
// queue-based model of the FIFO and a bus monitor enforcing the OPLL timing rules.
module tb_jtpang_fmwr;
  localparam int AW = 4, DEPTH = 16, ADDR_WAIT = 12, DATA_WAIT = 84;

  logic clk = 1'b0, rst_n = 1'b0, cen = 1'b0, in_we = 1'b0, in_a0 = 1'b0;
  logic [7:0] in_din = '0;
  logic in_full, ovf, busy, fm_cs, wr_n, a0;
  logic [AW:0] level;
  logic [7:0] dout;

  jtpang_fmwr #(.AW(AW), .ADDR_WAIT(ADDR_WAIT), .DATA_WAIT(DATA_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .in_we(in_we), .in_a0(in_a0), .in_din(in_din),
    .in_full(in_full), .level(level), .ovf(ovf), .busy(busy),
    .fm_cs(fm_cs), .wr_n(wr_n), .a0(a0), .dout(dout));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cen_mode = 0, cyc = 0;
  bit mon_en = 0;
  logic [8:0] m_q[$];
  int m_level = 0;
  bit m_ovf = 0;
  int n_writes = 0, n_coll = 0;
  bit coll_pend = 0;
  bit p_cs = 0, p_wr_n = 1, p_a0 = 0;
  logic [7:0] p_dout = '0;
  bit had_wr = 0, last_a0 = 0, st_cen = 0;
  int gap = 0;
  logic [8:0] cur = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int need_gap(input bit a);
    return a ? DATA_WAIT : ADDR_WAIT;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_level = 0; m_ovf = 0; coll_pend = 0;
    p_cs = 0; p_wr_n = 1; p_a0 = 0; p_dout = '0;
    had_wr = 0; st_cen = 0; gap = 0;
  endtask

  // One snapshot per clock cycle, taken while inputs and outputs are stable
  task automatic monitor();
    logic [8:0] exp;
    if (fm_cs && !p_cs) begin
      chk("setup_wr_n", wr_n, 1);
      if (had_wr) chk("gap_cen", gap >= need_gap(last_a0), 1);
      if (m_q.size() == 0) chk("spurious_cs", fm_cs, 0);
      else begin
        exp = m_q.pop_front();
        m_level--;
        chk("wr_data", {a0, dout}, exp);
        if (coll_pend) begin
          n_coll++;
          chk("full_pushpop_level", level, DEPTH - 1);
        end
      end
      cur = {a0, dout};
      n_writes++;
      st_cen = 0;
    end else begin
      chk("bus_stable", {a0, dout}, {p_a0, p_dout});
    end
    coll_pend = 0;
    if (!wr_n) begin
      if (p_wr_n) chk("strobe_cs", fm_cs, 1);
      if (cen) st_cen = 1;
    end
    if (wr_n && !p_wr_n) begin
      chk("strobe_cen", st_cen, 1);
      chk("release_cs", fm_cs, 0);
      had_wr = 1; last_a0 = cur[8]; gap = 0;
    end
    if (!fm_cs && wr_n && cen) gap++;
    chk("level", level, m_level);
    chk("ovf", ovf, m_ovf);
    chk("in_full", in_full, m_level == DEPTH);
    p_cs = fm_cs; p_wr_n = wr_n; p_a0 = a0; p_dout = dout;
  endtask

  task automatic tick();
    bit acc, drop;
    if (mon_en) monitor();
    acc  = in_we && (m_level < DEPTH);
    drop = in_we && !acc;
    @(posedge clk);
    cyc++;
    if (!rst_n) model_clear();
    else begin
      if (acc) begin m_q.push_back({in_a0, in_din}); m_level++; end
      if (drop) begin m_ovf = 1; coll_pend = 1; end
    end
    #1;
    case (cen_mode)
      0:       cen = 1'b0;
      1:       cen = (cyc % 4 == 0);
      default: cen = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic push(input bit a, input logic [7:0] d);
    in_we = 1'b1; in_a0 = a; in_din = d;
    tick();
    in_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && busy; i++) tick();
    chk("idle_timeout", busy, 0);
    if (had_wr) chk("final_gap", gap >= need_gap(last_a0), 1);
  endtask

  initial begin
    int w0, c0, pushed;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fm_cs", fm_cs, 0);
    chk("rst_wr_n", wr_n, 1);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", in_full, 0);
    chk("rst_bus", {a0, dout}, 9'h000);
    rst_n = 1'b1;
    model_clear();
    mon_en = 1;

    // Latency of a single address write
    cen_mode = 1;
    w0 = n_writes;
    push(1'b0, 8'h10);
    chk("lat_e0_cs", fm_cs, 0);
    chk("lat_e0_busy", busy, 1);
    tick(); chk("lat_e1_cs", fm_cs, 0);
    tick(); chk("lat_e2_cs", fm_cs, 1); chk("lat_e2_wr_n", wr_n, 1);
    tick(); chk("lat_e3_wr_n", wr_n, 0);
    wait_idle(1000);
    chk("lat_writes", n_writes - w0, 1);

    // Address then data write, ordered
    w0 = n_writes;
    push(1'b0, 8'h30);
    push(1'b1, 8'hE5);
    wait_idle(2000);
    chk("pair_writes", n_writes - w0, 2);

    // Overflow with cen stalled: first entry is popped into a stalled strobe
    do_reset();
    cen_mode = 0;
    w0 = n_writes;
    for (int i = 0; i < 18; i++) push(1'(i), 8'(8'h40 + i));
    chk("ovf_level", level, DEPTH);
    chk("ovf_full", in_full, 1);
    chk("ovf_flag", ovf, 1);
    chk("ovf_busy", busy, 1);
    repeat (20) tick();
    chk("stall_wr_n", wr_n, 0);
    cen_mode = 1;
    wait_idle(8000);
    chk("ovf_writes", n_writes - w0, 17);
    chk("ovf_sticky", ovf, 1);
    chk("ovf_drain_level", level, 0);

    // Full FIFO while the FSM pops: simultaneous push must be dropped
    do_reset();
    cen_mode = 0;
    for (int i = 0; i < 17; i++) push(1'b0, 8'(i));
    chk("coll_fill_level", level, DEPTH);
    chk("coll_fill_ovf", ovf, 0);
    cen_mode = 1;
    c0 = n_coll;
    in_we = 1'b1; in_a0 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      in_din = 8'($urandom);
      tick();
    end
    in_we = 1'b0;
    chk("coll_seen", n_coll > c0, 1);
    chk("coll_ovf", ovf, 1);
    wait_idle(3000);

    // Reset while wr_n is low
    cen_mode = 0;
    push(1'b1, 8'hA5);
    for (int i = 0; i < 10 && wr_n; i++) tick();
    chk("mid_strobe_wr_n", wr_n, 0);
    do_reset();
    chk("mid_rst_wr_n", wr_n, 1);
    chk("mid_rst_cs", fm_cs, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_busy", busy, 0);
    cen_mode = 2;
    w0 = n_writes;
    repeat (200) tick();
    chk("mid_rst_no_writes", n_writes - w0, 0);

    // Random traffic under random cen
    w0 = n_writes;
    pushed = 0;
    for (int i = 0; i < 60000 && pushed < 200; i++) begin
      if (m_level < 12 && $urandom_range(0, 7) == 0) begin
        in_we = 1'b1; in_a0 = 1'($urandom_range(0, 1)); in_din = 8'($urandom);
        pushed++;
      end
      tick();
      in_we = 1'b0;
    end
    wait_idle(3000);
    chk("rnd_all_written", n_writes - w0, 200);
    chk("rnd_model_empty", m_q.size(), 0);
    chk("rnd_ovf", ovf, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
